ysyx_23060236_mtime_reader: RTL and testbench

AXI4-Lite read-channel initiator that fetches the 64-bit machine timer from the CLINT as two 32-bit beats and returns one coherent 64-bit value to the core. It sits between the CSR/`rdtime` logic and the CLINT's read port, driving AR/R and never touching the write channels. It owns the hi/lo tear problem: a low-word rollover between the two beats must never yield a torn value.

---
 rtl/ysyx_23060236_mtime_reader_if.sv | 20 ++
 rtl/ysyx_23060236_mtime_reader.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_23060236_mtime_reader.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060236_mtime_reader_if.sv
// rtl/ysyx_23060236_mtime_reader_if.sv - AXI4-Lite read channel (AR/R) between the mtime reader and the CLINT
interface ysyx_23060236_mtime_reader_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060236_mtime_reader.sv
// rtl/ysyx_23060236_mtime_reader.sv - fetches 64-bit mtime as two 32-bit AXI4-Lite beats without tearing
// YSYX_23060236_MTIME_CONSISTENT_EN: hi-lo-hi sequence with bounded retry; undefined: single lo-hi pass.
module ysyx_23060236_mtime_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  ysyx_23060236_mtime_reader_if.master bus
);

  localparam logic [31:0] ADDR_HI = BASE_ADDR + 32'd4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_AR_HI1 = 3'd1;
  localparam logic [2:0] S_R_HI1  = 3'd2;
  localparam logic [2:0] S_AR_LO  = 3'd3;
  localparam logic [2:0] S_R_LO   = 3'd4;
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
  localparam logic [2:0] S_AR_HI2 = 3'd5;
  localparam logic [2:0] S_R_HI2  = 3'd6;
  localparam logic [2:0] S_FIRST  = S_AR_HI1;
`else
  localparam logic [2:0] S_FIRST  = S_AR_LO;
`endif
  localparam logic [2:0] S_DONE   = 3'd7;

  if (MAX_RETRY < 1 || MAX_RETRY > 15) begin : g_bad_max_retry
    $error("MAX_RETRY must lie in 1..15");
  end

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [31:0] lo_q;
  logic        r_fire;
  logic        r_bad;
  logic        done_set;
  logic [63:0] done_data;
  logic        done_err;

  assign r_fire = bus.rvalid & bus.rready;
  assign r_bad  = bus.rresp != 2'b00;

`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  logic [31:0] hi1_q;
  logic [3:0]  retry_cnt;
  logic        hi_match;
  logic        can_retry;

  // rdata is the second hi sample; comparing it live avoids a separate hi2 register.
  assign hi_match  = bus.rdata == hi1_q;
  assign can_retry = retry_cnt < RETRY_LIMIT;
`endif

  always_comb begin
    state_nxt = state;
    done_data = 64'd0;
    done_err  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = S_FIRST;
      end
      S_AR_HI1: begin
        if (bus.arready) state_nxt = S_R_HI1;
      end
      S_R_HI1: begin
        if (r_fire) begin
          if (r_bad) begin
            state_nxt = S_DONE;
            done_err  = 1'b1;
          end else begin
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
            state_nxt = S_AR_LO;
`else
            state_nxt = S_DONE;
            done_data = {bus.rdata, lo_q};
`endif
          end
        end
      end
      S_AR_LO: begin
        if (bus.arready) state_nxt = S_R_LO;
      end
      S_R_LO: begin
        if (r_fire) begin
          if (r_bad) begin
            state_nxt = S_DONE;
            done_err  = 1'b1;
          end else begin
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
            state_nxt = S_AR_HI2;
`else
            state_nxt = S_AR_HI1;
`endif
          end
        end
      end
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
      S_AR_HI2: begin
        if (bus.arready) state_nxt = S_R_HI2;
      end
      S_R_HI2: begin
        if (r_fire) begin
          if (r_bad) begin
            state_nxt = S_DONE;
            done_err  = 1'b1;
          end else if (hi_match) begin
            state_nxt = S_DONE;
            done_data = {hi1_q, lo_q};
          end else if (can_retry) begin
            state_nxt = S_AR_LO;
          end else begin
            state_nxt = S_DONE;
            done_data = {bus.rdata, lo_q};
            done_err  = 1'b1;
          end
        end
      end
`endif
      S_DONE: begin
        if (resp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done_set = (state_nxt == S_DONE) && (state != S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      lo_q      <= 32'd0;
      resp_data <= 64'd0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (done_set) begin
        resp_data <= done_data;
        resp_err  <= done_err;
      end
      if (r_fire && !r_bad && state == S_R_LO) lo_q <= bus.rdata;
    end
  end

`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hi1_q     <= 32'd0;
      retry_cnt <= 4'd0;
    end else begin
      if (state == S_IDLE && req_valid) retry_cnt <= 4'd0;
      if (r_fire && !r_bad && state == S_R_HI1) hi1_q <= bus.rdata;
      // A mismatching hi2 becomes the reference for the next lo/hi pair.
      if (r_fire && !r_bad && state == S_R_HI2 && !hi_match && can_retry) begin
        hi1_q     <= bus.rdata;
        retry_cnt <= (retry_cnt == 4'hF) ? 4'hF : retry_cnt + 4'd1;
      end
    end
  end

  assign bus.arvalid = (state == S_AR_HI1) || (state == S_AR_LO) || (state == S_AR_HI2);
  assign bus.rready  = (state == S_R_HI1) || (state == S_R_LO) || (state == S_R_HI2);
  assign bus.araddr  = ((state == S_AR_HI1) || (state == S_AR_HI2)) ? ADDR_HI : BASE_ADDR;
`else
  assign bus.arvalid = (state == S_AR_HI1) || (state == S_AR_LO);
  assign bus.rready  = (state == S_R_HI1) || (state == S_R_LO);
  assign bus.araddr  = (state == S_AR_HI1) ? ADDR_HI : BASE_ADDR;
`endif

  assign req_ready  = state == S_IDLE;
  assign resp_valid = state == S_DONE;

endmodule

// File: tb/tb_ysyx_23060236_mtime_reader.sv
// tb/tb_ysyx_23060236_mtime_reader.sv - randomized bench with a scripted CLINT and a sequence-level reference model
module tb_ysyx_23060236_mtime_reader;
  localparam logic [31:0] BASE    = 32'h0200_0000;
  localparam logic [31:0] HI_ADDR = BASE + 32'd4;
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
  localparam int MAX_RETRY = 3;
  localparam int LO_BEAT   = 1;
`else
  localparam int LO_BEAT   = 0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic        resp_err;

  ysyx_23060236_mtime_reader_if bus();

  ysyx_23060236_mtime_reader #(.BASE_ADDR(BASE)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Per-transaction CLINT script: successive hi reads and lo reads return these in order.
  logic [31:0] hi_s [8];
  logic [31:0] lo_s [8];
  int          err_beat;
  int          hi_i, lo_i, beat_i, stall_cnt;
  bit          stall_en, spurious_en, hold_lo_r;
  bit          overlap, unstable;
  logic [31:0] got_addrs [$];
  logic [31:0] exp_addrs [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit issue(input logic [31:0] a);
    exp_addrs.push_back(a);
    return (exp_addrs.size() - 1) == err_beat;
  endfunction

  task automatic model(output logic [63:0] d, output logic e, output int nb);
    logic [31:0] l;
    bit bad;
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
    logic [31:0] h1, h2;
    int hn, ln, retries;
    hn = 0; ln = 0; retries = 0; h1 = 0; h2 = 0;
`endif
    exp_addrs.delete();
    d = '0; e = 1'b0; l = '0;
`ifdef YSYX_23060236_MTIME_CONSISTENT_EN
    bad = issue(HI_ADDR);
    if (!bad) begin h1 = hi_s[0]; hn = 1; end
    while (!bad) begin
      bad = issue(BASE);
      if (bad) break;
      l = lo_s[ln]; ln++;
      bad = issue(HI_ADDR);
      if (bad) break;
      h2 = hi_s[hn]; hn++;
      if (h2 == h1) begin d = {h1, l}; break; end
      if (retries == MAX_RETRY) begin d = {h2, l}; e = 1'b1; break; end
      retries++;
      h1 = h2;
    end
`else
    bad = issue(BASE);
    if (!bad) begin
      l = lo_s[0];
      bad = issue(HI_ADDR);
      if (!bad) d = {hi_s[0], l};
    end
`endif
    if (bad) begin d = '0; e = 1'b1; end
    nb = exp_addrs.size();
  endtask

  initial begin : clint_slave
    int ar_wait, r_wait;
    bit pending;
    logic [31:0] held_addr, nd;
    logic [1:0]  nr;
    ar_wait = -1; r_wait = 0; pending = 0; held_addr = 0; nd = 0; nr = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    forever begin
      @(negedge clock);
      #1;
      bus.arready = 0; bus.rvalid = 0; bus.rresp = 2'b00; bus.rdata = 32'h0;
      if (reset) begin
        pending = 0; ar_wait = -1;
      end else begin
        if (bus.arvalid && bus.rready) overlap = 1;
        if (pending) begin
          if (hold_lo_r && held_addr == BASE) begin
          end else if (r_wait > 0) begin
            r_wait--; stall_cnt++;
          end else begin
            bus.rvalid = 1; bus.rdata = nd; bus.rresp = nr; pending = 0;
          end
        end else if (bus.arvalid) begin
          if (ar_wait < 0) begin
            ar_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
            held_addr = bus.araddr;
          end else if (bus.araddr !== held_addr) begin
            unstable = 1;
          end
          if (ar_wait > 0) begin
            ar_wait--; stall_cnt++;
          end else begin
            bus.arready = 1;
            // Garbage R beat alongside the AR handshake; the reader must not take it.
            if (spurious_en && $urandom_range(0, 1) == 1) begin
              bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b10;
            end
            got_addrs.push_back(held_addr);
            if (held_addr == HI_ADDR) begin nd = (hi_i < 8) ? hi_s[hi_i] : 32'h0; hi_i++; end
            else begin nd = (lo_i < 8) ? lo_s[lo_i] : 32'h0; lo_i++; end
            nr = (beat_i == err_beat) ? 2'b10 : 2'b00;
            beat_i++;
            pending = 1;
            r_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
            ar_wait = -1;
          end
        end
      end
    end
  end

  task automatic clear_script();
    for (int k = 0; k < 8; k++) begin hi_s[k] = 32'h0; lo_s[k] = 32'h0; end
    err_beat = -1;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_arvalid", bus.arvalid, 0);
    check_eq("rst_rready", bus.rready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_resp_data", resp_data, 0);
    check_eq("rst_araddr", bus.araddr, BASE);
    check_eq("rst_req_ready", req_ready, 1);
  endtask

  task automatic run_txn(input int hold_req, input int resp_dly, input bit rr_early);
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_nb, cyc, mism;
    bit          seen;
    model(exp_d, exp_e, exp_nb);
    hi_i = 0; lo_i = 0; beat_i = 0; stall_cnt = 0;
    got_addrs.delete(); overlap = 0; unstable = 0;
    @(negedge clock);
    check_eq("idle_req_ready", req_ready, 1);
    req_valid = 1; resp_ready = rr_early;
    cyc = 0; seen = 0;
    while (!seen && cyc < 400) begin
      @(negedge clock);
      cyc++;
      if (cyc > hold_req) req_valid = 0;
      if (cyc == 1) begin
        check_eq("busy_req_ready", req_ready, 0);
        check_eq("arvalid_rise", bus.arvalid, 1);
      end
      seen = resp_valid;
    end
    req_valid = 0;
    check_eq("resp_timeout", seen, 1);
    if (seen) begin
      check_eq("latency", cyc, 1 + 2 * exp_nb + stall_cnt);
      check_eq("resp_data", resp_data, exp_d);
      check_eq("resp_err", resp_err, exp_e);
      if (rr_early) begin
        @(negedge clock);
        check_eq("pulse_drop", resp_valid, 0);
      end else begin
        repeat (resp_dly) @(negedge clock);
        check_eq("held_valid", resp_valid, 1);
        check_eq("held_data", resp_data, exp_d);
        resp_ready = 1;
        @(negedge clock);
        check_eq("resp_release", resp_valid, 0);
      end
      check_eq("back_idle", req_ready, 1);
    end
    resp_ready = 0;
    mism = 0;
    for (int i = 0; i < got_addrs.size() && i < exp_addrs.size(); i++)
      if (got_addrs[i] !== exp_addrs[i]) mism++;
    check_eq("ar_count", got_addrs.size(), exp_addrs.size());
    check_eq("ar_sequence", mism, 0);
    check_eq("ar_r_overlap", overlap, 0);
    check_eq("araddr_stable", unstable, 0);
  endtask

  task automatic reset_mid();
    int  cyc;
    bit  hit;
    clear_script();
    hi_s[0] = 32'h9; hi_s[1] = 32'h9; lo_s[0] = 32'h1234;
    hi_i = 0; lo_i = 0; beat_i = 0; got_addrs.delete();
    stall_en = 0; spurious_en = 0; hold_lo_r = 1;
    @(negedge clock);
    req_valid = 1;
    @(negedge clock);
    req_valid = 0;
    hit = 0; cyc = 0;
    while (!hit && cyc < 50) begin
      if (bus.rready === 1'b1 && got_addrs.size() > 0 && got_addrs[$] == BASE) hit = 1;
      else begin @(negedge clock); cyc++; end
    end
    check_eq("reach_r_lo", hit, 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    check_reset_outputs();
    hold_lo_r = 0;
  endtask

  task automatic random_script();
    logic [31:0] base;
    clear_script();
    base = $urandom;
    for (int k = 0; k < 8; k++) begin
      hi_s[k] = base + (($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0);
      lo_s[k] = $urandom;
    end
    err_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
  endtask

  initial begin : main
    reset = 1; req_valid = 0; resp_ready = 0;
    stall_en = 0; spurious_en = 0; hold_lo_r = 0;
    overlap = 0; unstable = 0;
    hi_i = 0; lo_i = 0; beat_i = 0; stall_cnt = 0;
    clear_script();
    repeat (3) @(negedge clock);
    check_reset_outputs();
    reset = 0;

    clear_script();
    hi_s[0] = 32'h1; hi_s[1] = 32'h1; lo_s[0] = 32'h10;
    run_txn(0, 0, 0);

    clear_script();
    hi_s[0] = 32'h5; hi_s[1] = 32'h6; hi_s[2] = 32'h6;
    lo_s[0] = 32'hFFFF_FFFF; lo_s[1] = 32'h3;
    run_txn(0, 0, 0);

    clear_script();
    for (int k = 0; k < 8; k++) begin
      hi_s[k] = 32'(k + 1);
      lo_s[k] = 32'hA0 + 32'(k);
    end
    run_txn(1, 2, 0);

    clear_script();
    hi_s[0] = 32'h7; hi_s[1] = 32'h7; lo_s[0] = 32'h55;
    err_beat = LO_BEAT;
    run_txn(0, 0, 1);

    stall_en = 1;
    random_script();
    run_txn(0, 4, 0);
    stall_en = 0;

    reset_mid();
    clear_script();
    hi_s[0] = 32'h42; hi_s[1] = 32'h42; lo_s[0] = 32'hCAFE;
    run_txn(0, 0, 0);

    for (int t = 0; t < 150; t++) begin
      random_script();
      stall_en    = $urandom_range(0, 1) == 1;
      spurious_en = $urandom_range(0, 1) == 1;
      run_txn(int'($urandom_range(0, 1)), int'($urandom_range(0, 4)), $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
